// File: rtl/prng_pkg.sv
// Shared defaults for the prng word buffer: parameter constants and a level-width helper.
// Optional feature macro used by the buffer: PRNG_BUF_STATS_EN.
package prng_pkg;

  localparam int PRNG_IN_BITS   = 2;
  localparam int PRNG_WORD_BITS = 16;
  localparam int PRNG_DEPTH     = 4;

  // Counter width able to hold 0..depth inclusive.
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/prng_word_buffer_if.sv
// Word-side valid/ready interface of the prng word buffer, plus occupancy level.
interface prng_word_buffer_if
  import prng_pkg::*;
#(
  parameter int WORD_BITS = PRNG_WORD_BITS,
  parameter int LVL_BITS  = lvl_width(PRNG_DEPTH)
) ();

  logic [WORD_BITS-1:0] word;
  logic                 word_valid;
  logic                 word_ready;
  logic [LVL_BITS-1:0]  level;

  modport master (output word, output word_valid, output level, input word_ready);
  modport slave  (input word, input word_valid, input level, output word_ready);

endinterface

// File: rtl/prng_word_fifo.sv
// Synchronous word FIFO with flush; read data is forced to zero while empty.
module prng_word_fifo
  import prng_pkg::*;
#(
  parameter int WORD_BITS = PRNG_WORD_BITS,
  parameter int DEPTH     = PRNG_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WORD_BITS-1:0]         wdata,
  output logic [WORD_BITS-1:0]         rdata,
  output logic                         full,
  output logic                         empty,
  output logic [lvl_width(DEPTH)-1:0]  level
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int LVL_BITS = lvl_width(DEPTH);

  logic [WORD_BITS-1:0] mem_q [DEPTH];
  logic [WORD_BITS-1:0] mem_d [DEPTH];
  logic [LVL_BITS-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LVL_BITS-1:0]  rd_cnt_q, rd_cnt_d;
  logic                 push_ok_s;
  logic                 pop_ok_s;

  assign level     = wr_cnt_q - rd_cnt_q;
  assign empty     = (level == {LVL_BITS{1'b0}});
  assign full      = (level == LVL_BITS'(DEPTH));
  // A pop on the same edge frees the slot a push into a full FIFO needs.
  assign push_ok_s = push & (~full | pop);
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = empty ? {WORD_BITS{1'b0}} : mem_q[rd_cnt_q[PTR_BITS-1:0]];

  // Next-state for storage and the full-width read/write counters.
  always_comb begin
    mem_d    = mem_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (flush) begin
      wr_cnt_d = {LVL_BITS{1'b0}};
      rd_cnt_d = {LVL_BITS{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_d[wr_cnt_q[PTR_BITS-1:0]] = wdata;
        wr_cnt_d = wr_cnt_q + LVL_BITS'(1);
      end else begin
        wr_cnt_d = wr_cnt_q;
      end
      if (pop_ok_s) begin
        rd_cnt_d = rd_cnt_q + LVL_BITS'(1);
      end else begin
        rd_cnt_d = rd_cnt_q;
      end
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WORD_BITS{1'b0}};
      end
      wr_cnt_q <= {LVL_BITS{1'b0}};
      rd_cnt_q <= {LVL_BITS{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

endmodule

// File: rtl/prng_word_buffer.sv
// Packs an IN_BITS-per-cycle random stream into WORD_BITS words and buffers them in a FIFO.
// Define PRNG_BUF_STATS_EN to add the saturating drop_cnt port.
module prng_word_buffer
  import prng_pkg::*;
#(
  parameter int IN_BITS   = PRNG_IN_BITS,
  parameter int WORD_BITS = PRNG_WORD_BITS,
  parameter int DEPTH     = PRNG_DEPTH
`ifdef PRNG_BUF_STATS_EN
  ,
  parameter int DROP_BITS = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_BITS-1:0]   random,
  input  logic                 enable,
  input  logic                 flush,
`ifdef PRNG_BUF_STATS_EN
  output logic [DROP_BITS-1:0] drop_cnt,
`endif
  prng_word_buffer_if.master   bus
);

  localparam int BEATS    = WORD_BITS / IN_BITS;
  localparam int CNT_BITS = $clog2(BEATS);
  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int LVL_BITS = PTR_BITS + 1;
  localparam int ASM_BITS = WORD_BITS - IN_BITS;

  logic [ASM_BITS-1:0]  asm_q, asm_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [WORD_BITS-1:0] full_word_s;
  logic                 last_beat_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [LVL_BITS-1:0]  fifo_level_s;

  assign full_word_s = {asm_q, random};
  assign last_beat_s = enable & (cnt_q == CNT_BITS'(BEATS - 1));
  assign push_s      = last_beat_s & ~flush;
  assign pop_s       = bus.word_ready & ~flush;

  // Assembler shift register and beat counter; flush wins over enable.
  always_comb begin
    asm_d = asm_q;
    cnt_d = cnt_q;
    if (flush) begin
      asm_d = {ASM_BITS{1'b0}};
      cnt_d = {CNT_BITS{1'b0}};
    end else if (enable) begin
      asm_d = full_word_s[ASM_BITS-1:0];
      cnt_d = last_beat_s ? {CNT_BITS{1'b0}} : cnt_q + CNT_BITS'(1);
    end else begin
      asm_d = asm_q;
      cnt_d = cnt_q;
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q <= {ASM_BITS{1'b0}};
      cnt_q <= {CNT_BITS{1'b0}};
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
    end
  end

  prng_word_fifo #(
    .WORD_BITS (WORD_BITS),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush),
    .wdata (full_word_s),
    .rdata (bus.word),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level_s)
  );

  assign bus.word_valid = ~fifo_empty_s;
  assign bus.level      = fifo_level_s;

`ifdef PRNG_BUF_STATS_EN
  logic                 drop_s;
  logic [DROP_BITS-1:0] drop_q, drop_d;

  // A full FIFO is non-empty, so word_ready alone tells whether a slot frees up.
  assign drop_s   = push_s & fifo_full_s & ~bus.word_ready;
  assign drop_cnt = drop_q;

  // Saturating drop counter, cleared only by reset.
  always_comb begin
    if (drop_s && !(&drop_q)) begin
      drop_d = drop_q + DROP_BITS'(1);
    end else begin
      drop_d = drop_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= {DROP_BITS{1'b0}};
    end else begin
      drop_q <= drop_d;
    end
  end
`endif

endmodule
